// File: rtl/seg_scan_driver.sv
// Six-digit multiplexed seven-segment scan driver for an HH:MM:SS display.
// Inputs are snapshotted once per frame; all outputs are registered one cycle behind the counters.
module seg_scan_driver #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned BLANK_CYC      = 500,
  parameter int unsigned BLINK_DIV      = 100,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] bcd_in,
  input  logic        blank_lz,
  input  logic [5:0]  blink_mask,
  input  logic [5:0]  dp_mask,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [5:0]  dig_sel,
  output logic        frame_tick
);

  localparam int unsigned CntW  = $clog2(SCAN_DIV);
  localparam int unsigned BcntW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [CntW-1:0]  CntMax   = CntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0]  BlankCyc = CntW'(BLANK_CYC);
  localparam logic [BcntW-1:0] BcntMax  = BcntW'(BLINK_DIV - 1);

  localparam logic [6:0] SegOff = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DpOff  = SEG_ACTIVE_LOW;
  localparam logic [5:0] DigOff = DIG_ACTIVE_LOW ? 6'h3F : 6'h00;

  logic [CntW-1:0]  cnt_q;
  logic [2:0]       idx_q;
  logic [BcntW-1:0] bcnt_q;
  logic             phase_q;
  logic [5:0][3:0]  snap_bcd_q;
  logic [5:0]       snap_blink_q;
  logic [5:0]       snap_dp_q;
  logic             snap_lz_q;

  logic [3:0] cur_digit;
  logic       dark;
  logic [6:0] seg_act;
  logic       dp_act;
  logic [5:0] dig_act;

  // Active-high segment pattern; non-BCD codes show a dash.
  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  always_comb begin
    cur_digit = snap_bcd_q[idx_q];
    dark      = (snap_blink_q[idx_q] && phase_q) ||
                ((idx_q == 3'd5) && snap_lz_q && (snap_bcd_q[5] == 4'd0));
    seg_act   = '0;
    dp_act    = 1'b0;
    dig_act   = '0;
    // Anti-ghosting: every digit stays off for the first BLANK_CYC cycles of a slot.
    if (cnt_q >= BlankCyc) begin
      dig_act = 6'b000001 << idx_q;
      if (!dark) begin
        seg_act = decode(cur_digit);
        dp_act  = snap_dp_q[idx_q];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      bcnt_q       <= '0;
      phase_q      <= 1'b0;
      snap_bcd_q   <= '0;
      snap_blink_q <= '0;
      snap_dp_q    <= '0;
      snap_lz_q    <= 1'b0;
      frame_tick   <= 1'b0;
      seg          <= SegOff;
      dp           <= DpOff;
      dig_sel      <= DigOff;
    end else begin
      seg        <= seg_act ^ {7{SEG_ACTIVE_LOW}};
      dp         <= dp_act ^ SEG_ACTIVE_LOW;
      dig_sel    <= dig_act ^ {6{DIG_ACTIVE_LOW}};
      frame_tick <= 1'b0;
      if (cnt_q == CntMax) begin
        cnt_q <= '0;
        if (idx_q == 3'd5) begin
          idx_q        <= '0;
          snap_bcd_q   <= bcd_in;
          snap_blink_q <= blink_mask;
          snap_dp_q    <= dp_mask;
          snap_lz_q    <= blank_lz;
          frame_tick   <= 1'b1;
          if (bcnt_q == BcntMax) begin
            bcnt_q  <= '0;
            phase_q <= ~phase_q;
          end else begin
            bcnt_q <= bcnt_q + BcntW'(1);
          end
        end else begin
          idx_q <= idx_q + 3'd1;
        end
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: a frame/slot-level reference model queues the expected
// outputs for every clock edge and a separate monitor pops and compares them.
module tb_seg_scan_driver;

  localparam int SD       = 4;
  localparam int BC       = 1;
  localparam int BD       = 2;
  localparam int FrameLen = SD * 6;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] bcd_in;
  logic        blank_lz;
  logic [5:0]  blink_mask;
  logic [5:0]  dp_mask;
  logic [6:0]  seg;
  logic        dp;
  logic [5:0]  dig_sel;
  logic        frame_tick;

  always #5 clk = ~clk;

  seg_scan_driver #(
    .SCAN_DIV      (SD),
    .BLANK_CYC     (BC),
    .BLINK_DIV     (BD),
    .SEG_ACTIVE_LOW(1'b1),
    .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bcd_in    (bcd_in),
    .blank_lz  (blank_lz),
    .blink_mask(blink_mask),
    .dp_mask   (dp_mask),
    .seg       (seg),
    .dp        (dp),
    .dig_sel   (dig_sel),
    .frame_tick(frame_tick)
  );

  typedef struct packed {
    logic [23:0] bcd;
    logic [5:0]  blink;
    logic [5:0]  dpm;
    logic        lz;
  } snap_t;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [5:0] dig;
    logic       tick;
  } out_t;

  typedef struct {
    int   k;
    out_t o;
  } exp_t;

  localparam out_t ResetOut = '{seg: 7'h7F, dp: 1'b1, dig: 6'h3F, tick: 1'b0};

  snap_t snaps[$];   // snaps[f] = inputs shown during frame f since reset release
  exp_t  exp_q[$];
  int    k;          // clock edges since reset release
  int    checks = 0;
  int    errors = 0;

  function automatic logic [6:0] seg_pattern(input logic [3:0] v);
    logic [6:0] tab [10];
    tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    if (v > 4'd9) return 7'h40;
    return tab[v];
  endfunction

  // Output after edge kk reflects the counter state held during cycle t = kk-1.
  function automatic out_t expect_out(input int kk);
    int    t, c, slot, d, f;
    bit    ph, dark;
    snap_t s;
    out_t  o;
    t    = kk - 1;
    c    = t % SD;
    slot = t / SD;
    d    = slot % 6;
    f    = slot / 6;
    s    = snaps[f];
    ph   = ((f / BD) % 2) == 1;
    o    = '0;
    if (c >= BC) begin
      o.dig[d] = 1'b1;
      dark = (s.blink[d] && ph) || (d == 5 && s.lz && s.bcd[23:20] == 4'd0);
      if (!dark) begin
        o.seg = seg_pattern(s.bcd[4*d +: 4]);
        o.dp  = s.dpm[d];
      end
    end
    o.seg  = ~o.seg;
    o.dp   = ~o.dp;
    o.dig  = ~o.dig;
    o.tick = (kk % FrameLen) == 0;
    return o;
  endfunction

  task automatic randomize_inputs();
    for (int i = 0; i < 5; i++) bcd_in[4*i +: 4] = 4'($urandom_range(0, 15));
    bcd_in[23:20] = 4'($urandom_range(0, 2));
    blank_lz      = 1'($urandom_range(0, 1));
    blink_mask    = 6'($urandom);
    dp_mask       = 6'($urandom);
  endtask

  // Entered and left at a negedge; one iteration per clock edge.
  task automatic run_cycles(input int n, input bit rnd);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      if (rnd && $urandom_range(0, 15) == 0) randomize_inputs();
      k++;
      if (k % FrameLen == 0)
        snaps.push_back('{bcd: bcd_in, blink: blink_mask, dpm: dp_mask, lz: blank_lz});
      e.k = k;
      e.o = expect_out(k);
      exp_q.push_back(e);
      @(negedge clk);
    end
  endtask

  task automatic model_reset();
    k = 0;
    snaps.delete();
    snaps.push_back('0);
    exp_q.delete();
  endtask

  task automatic check_reset(input string tag);
    out_t act;
    act = {seg, dp, dig_sel, frame_tick};
    checks++;
    if (act !== ResetOut) begin
      errors++;
      $display("FAIL reset_%s: got seg=%h dp=%b dig=%h tick=%b, want seg=%h dp=%b dig=%h tick=%b",
               tag, act.seg, act.dp, act.dig, act.tick,
               ResetOut.seg, ResetOut.dp, ResetOut.dig, ResetOut.tick);
    end
  endtask

  // Monitor: pops one expectation per edge while out of reset.
  always begin
    exp_t e;
    out_t act;
    @(posedge clk);
    #1;
    checks++;
    if ($countones(~dig_sel) > 1) begin
      errors++;
      $display("FAIL onehot: got dig_sel=%h, want at most one low bit", dig_sel);
    end
    if (!rst && exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {seg, dp, dig_sel, frame_tick};
      checks++;
      if (act !== e.o) begin
        errors++;
        $display("FAIL out k=%0d: got seg=%h dp=%b dig=%h tick=%b, want seg=%h dp=%b dig=%h tick=%b",
                 e.k, act.seg, act.dp, act.dig, act.tick, e.o.seg, e.o.dp, e.o.dig, e.o.tick);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b0;
    bcd_in     = '0;
    blank_lz   = 1'b0;
    blink_mask = '0;
    dp_mask    = '0;
    model_reset();
    #1 rst = 1'b1;
    #2 check_reset("async");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_reset("held");
    end
    rst    = 1'b0;
    bcd_in = 24'h235948;
    // First frame shows the zero snapshot, then 23:59:48.
    run_cycles(3 * FrameLen, 1'b0);
    // Mid-frame change must not tear the display.
    run_cycles(10, 1'b0);
    bcd_in = 24'h000000;
    run_cycles(2 * FrameLen - 10, 1'b0);
    // Leading-zero blanking on and off.
    bcd_in   = 24'h095959;
    blank_lz = 1'b1;
    run_cycles(2 * FrameLen, 1'b0);
    blank_lz = 1'b0;
    run_cycles(2 * FrameLen, 1'b0);
    // Blink on digits 0 and 1.
    blink_mask = 6'h03;
    run_cycles(6 * FrameLen, 1'b0);
    blink_mask = 6'h00;
    // Non-BCD digit 3 and dp on digit 2.
    bcd_in  = 24'h12F456;
    dp_mask = 6'h04;
    run_cycles(2 * FrameLen, 1'b0);
    // Random traffic.
    run_cycles(3000, 1'b1);
    // Asynchronous reset in the middle of a slot.
    run_cycles($urandom_range(1, FrameLen - 1), 1'b1);
    #2 rst = 1'b1;
    #1 check_reset("mid");
    model_reset();
    @(negedge clk);
    check_reset("mid_held");
    @(negedge clk);
    rst = 1'b0;
    run_cycles(20 * FrameLen, 1'b1);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
